// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone scheduler:
//   - state_t      : scheduler FSM states (IDLE / PLAY / GAP)
//   - ID_* consts  : requester identifiers, ID_LOSE has the highest priority
//   - ID_W, N_REQ  : requester id width and number of requesters
//   - HP_W         : width of one half-period entry
//   - cnt_w        : counter width able to hold 0 .. n-1 (at least 1 bit)
//   - max_half     : largest half-period in a table (sizes the divider counter)
//   - hi_idx       : highest-priority set requester in a request vector
// -----------------------------------------------------------------------------
package tone_pkg;

    localparam int ID_W  = 2;
    localparam int N_REQ = 4;
    localparam int HP_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] ID_LOSE   = 2'd3;
    localparam logic [ID_W-1:0] ID_LEVEL  = 2'd2;
    localparam logic [ID_W-1:0] ID_BTN_HI = 2'd1;
    localparam logic [ID_W-1:0] ID_BTN_LO = 2'd0;

    // Width of a counter that runs 0 .. n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_half(input logic [N_REQ-1:0][HP_W-1:0] hp);
        int m;
        m = 1;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(hp[i]) > m) begin
                m = int'(hp[i]);
            end
        end
        return m;
    endfunction

    // Fixed priority: LOSE > LEVEL > BTN_HI > BTN_LO. Returns BTN_LO when empty,
    // callers qualify with a non-zero test.
    function automatic logic [ID_W-1:0] hi_idx(input logic [N_REQ-1:0] v);
        if (v[ID_LOSE]) begin
            return ID_LOSE;
        end else if (v[ID_LEVEL]) begin
            return ID_LEVEL;
        end else if (v[ID_BTN_HI]) begin
            return ID_BTN_HI;
        end else begin
            return ID_BTN_LO;
        end
    endfunction

endpackage

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Square-wave divider. While enabled the output starts low on the restart
// cycle and toggles after every half_p cycles. Disabled -> output low and the
// divider is held cleared.
// Ports:
//   CLK      in  system clock
//   RST      in  synchronous active-high reset
//   enable   in  divider running (scheduler in PLAY)
//   restart  in  first cycle of a new tone; phase and count start over
//   half_p   in  half-period in clock cycles
//   snd      out square wave
// -----------------------------------------------------------------------------
module tone_gen
    import tone_pkg::*;
#(
    parameter int CW = 16
)(
    input  logic            CLK,
    input  logic            RST,
    input  logic            enable,
    input  logic            restart,
    input  logic [HP_W-1:0] half_p,
    output logic            snd
);

    localparam int HW1 = HP_W + 1;

    logic [CW-1:0]  r_cnt;
    logic           r_lvl;

    logic [CW-1:0]  w_cnt_cur;
    logic           w_lvl_cur;
    logic [HP_W:0]  w_cnt_ext;
    logic           w_wrap;

    // On the restart cycle the stale phase of a previous tone is ignored, so
    // the restart cycle itself already counts as the first low cycle.
    always_comb begin
        w_cnt_cur = restart ? '0   : r_cnt;
        w_lvl_cur = restart ? 1'b0 : r_lvl;
        w_cnt_ext = HW1'(w_cnt_cur);
        // ">=" rather than "==" so a zero or one half-period toggles every cycle
        w_wrap    = (w_cnt_ext + HW1'(1)) >= {1'b0, half_p};
    end

    always_ff @(posedge CLK) begin
        if (RST || !enable) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_lvl <= ~w_lvl_cur;
        end else begin
            r_cnt <= w_cnt_cur + CW'(1);
            r_lvl <= w_lvl_cur;
        end
    end

    assign snd = enable & w_lvl_cur;

endmodule

// File: rtl/tone_sched.sv
// -----------------------------------------------------------------------------
// tone_sched
// Priority tone scheduler for a single speaker. Requests are latched into a
// pending register; the highest pending id is granted, played for
// TONE_MS milliseconds as a square wave, followed by GAP_MS milliseconds of
// silence before the next grant.
//
// Build option:
//   TONE_SCHED_PREEMPT_EN - when defined, a higher-priority request aborts the
//                           tone in progress (no done pulse, no re-queue) and
//                           is granted on the next edge without a gap.
//
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   req[3:0]   in   tone request per requester, req[3] highest priority
//   snd        out  speaker square wave
//   busy       out  scheduler not IDLE
//   active_id  out  requester being served (held outside PLAY)
//   grant      out  one-cycle pulse on the first cycle of a tone
//   done       out  one-cycle pulse on the last cycle of a completed tone
// -----------------------------------------------------------------------------
module tone_sched
    import tone_pkg::*;
#(
    parameter int TICKS_PER_MS = 25000,
    parameter int TONE_MS      = 300,
    parameter int GAP_MS       = 50,
    parameter logic [N_REQ-1:0][HP_W-1:0] HALF_P =
        {20'd28409, 20'd37879, 20'd47801, 20'd56818}
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    output logic             snd,
    output logic             busy,
    output logic [ID_W-1:0]  active_id,
    output logic             grant,
    output logic             done
);

    localparam int PLAY_CYC = TONE_MS * TICKS_PER_MS;
    localparam int GAP_CYC  = GAP_MS * TICKS_PER_MS;
    localparam bit HAS_GAP  = (GAP_CYC > 0);

    localparam int PW = cnt_w(PLAY_CYC);
    localparam int GW = cnt_w(GAP_CYC);
    localparam int HW = cnt_w(max_half(HALF_P));

    localparam logic [PW-1:0] PLAY_LAST = PW'(PLAY_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    state_t            r_state;
    logic [N_REQ-1:0]  r_pending;
    logic [ID_W-1:0]   r_active_id;
    logic [PW-1:0]     r_play_cnt;
    logic [GW-1:0]     r_gap_cnt;

    state_t            w_state_next;
    logic [N_REQ-1:0]  w_pending_next;
    logic [ID_W-1:0]   w_active_next;
    logic [PW-1:0]     w_play_cnt_next;
    logic [GW-1:0]     w_gap_cnt_next;

    logic [N_REQ-1:0]  w_req_all;
    logic [ID_W-1:0]   w_top_id;
    logic [N_REQ-1:0]  w_top_onehot;
    logic              w_preempt;
    logic              w_grant;
    logic              w_done;
    logic              w_play;

    // Requests seen this cycle count as pending, so a request in IDLE is
    // granted on the very next edge.
    assign w_req_all = r_pending | req;
    assign w_top_id  = hi_idx(w_req_all);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign w_top_onehot[gi] = (w_top_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_preempt = 1'b0;
`ifdef TONE_SCHED_PREEMPT_EN
        w_preempt = (r_state == PLAY) && (|w_req_all) && (w_top_id > r_active_id);
`else
        w_preempt = 1'b0;
`endif
    end

    // Next-state logic. A grant (from IDLE, or a preemption in PLAY) is the
    // only place that clears a pending bit; everything else just ORs in req.
    always_comb begin
        w_state_next    = r_state;
        w_pending_next  = w_req_all;
        w_active_next   = r_active_id;
        w_play_cnt_next = r_play_cnt;
        w_gap_cnt_next  = r_gap_cnt;

        case (r_state)
            IDLE: begin
                if (|w_req_all) begin
                    w_state_next    = PLAY;
                    w_active_next   = w_top_id;
                    w_pending_next  = w_req_all & ~w_top_onehot;
                    w_play_cnt_next = '0;
                end
            end

            PLAY: begin
                if (w_preempt) begin
                    // Aborted tone is dropped, not re-queued.
                    w_state_next    = PLAY;
                    w_active_next   = w_top_id;
                    w_pending_next  = w_req_all & ~w_top_onehot;
                    w_play_cnt_next = '0;
                end else if (r_play_cnt == PLAY_LAST) begin
                    w_play_cnt_next = '0;
                    w_gap_cnt_next  = '0;
                    if (HAS_GAP) begin
                        w_state_next = GAP;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_play_cnt_next = r_play_cnt + PW'(1);
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next   = IDLE;
                    w_gap_cnt_next = '0;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GW'(1);
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_active_id <= '0;
            r_play_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_active_id <= w_active_next;
            r_play_cnt  <= w_play_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
        end
    end

    // The play counter is zero exactly on the first cycle of every tone,
    // including one started by preemption, so grant and the divider restart
    // both follow from it.
    assign w_play  = (r_state == PLAY);
    assign w_grant = w_play && (r_play_cnt == '0);
    assign w_done  = w_play && (r_play_cnt == PLAY_LAST) && !w_preempt;

    tone_gen #(
        .CW(HW)
    ) u_tone_gen (
        .CLK     (CLK),
        .RST     (RST),
        .enable  (w_play),
        .restart (w_grant),
        .half_p  (HALF_P[r_active_id]),
        .snd     (snd)
    );

    assign busy      = (r_state != IDLE);
    assign active_id = r_active_id;
    assign grant     = w_grant;
    assign done      = w_done;

endmodule

// File: tb/tb_tone_sched.sv
// -----------------------------------------------------------------------------
// tb_tone_sched
// Self-checking bench for tone_sched with TICKS_PER_MS=4, TONE_MS=3, GAP_MS=1,
// HALF_P={2,3,4,5}: tones last 12 cycles, gaps 4 cycles.
// Expected grant ids are queued as stimulus is driven and popped on each grant
// pulse; a negedge monitor checks every cycle of every tone and gap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_sched;

    localparam int PLAY_CYC = 12;
    localparam int GAP_CYC  = 4;
    localparam logic [3:0][19:0] TB_HALF = {20'd2, 20'd3, 20'd4, 20'd5};
`ifdef TONE_SCHED_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       snd;
    logic       busy;
    logic [1:0] active_id;
    logic       grant;
    logic       done;

    tone_sched #(
        .TICKS_PER_MS (4),
        .TONE_MS      (3),
        .GAP_MS       (1),
        .HALF_P       (TB_HALF)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .snd       (snd),
        .busy      (busy),
        .active_id (active_id),
        .grant     (grant),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   q_exp[$];
    int   dones    = 0;
    bit   chk_en   = 1'b0;
    logic rst_q    = 1'b0;

    bit   m_play = 1'b0;
    bit   m_gap  = 1'b0;
    int   m_cyc  = 0;
    int   m_gcyc = 0;
    int   m_id   = 0;

    typedef struct {
        string      name;
        logic [3:0] req0;
        int         hold0;
        int         d1;
        logic [3:0] req1;
        int         n_exp;
        int         exp_id[4];
        int         dones;
        int         dones_pre;
    } vec_t;

    vec_t vecs[8];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input string nm, input logic [3:0] r0, input int h0,
                                input int d1, input logic [3:0] r1, input int n,
                                input int e0, input int e1, input int e2, input int e3,
                                input int dn, input int dnp);
        vec_t v;
        v.name = nm; v.req0 = r0; v.hold0 = h0; v.d1 = d1; v.req1 = r1;
        v.n_exp = n;
        v.exp_id[0] = e0; v.exp_id[1] = e1; v.exp_id[2] = e2; v.exp_id[3] = e3;
        v.dones = dn; v.dones_pre = dnp;
        return v;
    endfunction

    always @(posedge CLK) rst_q <= RST;

    // Cycle monitor: outputs sampled mid-cycle, one step after each edge.
    always @(negedge CLK) begin
        if (rst_q === 1'b1) begin
            chk("rst_snd",   32'(snd),       32'd0);
            chk("rst_busy",  32'(busy),      32'd0);
            chk("rst_grant", 32'(grant),     32'd0);
            chk("rst_done",  32'(done),      32'd0);
            chk("rst_id",    32'(active_id), 32'd0);
            m_play = 1'b0; m_gap = 1'b0; m_id = 0;
        end else if (chk_en) begin
            if (grant === 1'b1) begin
                chk("grant_expected", 32'(q_exp.size() > 0), 32'd1);
                chk("grant_in_gap", 32'(m_gap), 32'd0);
`ifdef TONE_SCHED_PREEMPT_EN
                if (m_play && q_exp.size() > 0) chk("preempt_higher", 32'(q_exp[0] > m_id), 32'd1);
`else
                chk("grant_in_play", 32'(m_play), 32'd0);
`endif
                if (q_exp.size() > 0) begin
                    m_id = q_exp.pop_front();
                    chk("grant_id", 32'(active_id), 32'(m_id));
                end
                $display("[%0t] grant id=%0d", $time, active_id);
                chk("grant_snd",  32'(snd),  32'd0);
                chk("grant_busy", 32'(busy), 32'd1);
                chk("grant_done", 32'(done), 32'd0);
                m_play = 1'b1; m_gap = 1'b0; m_cyc = 1;
            end else if (m_play) begin
                m_cyc++;
                chk("play_snd",  32'(snd), 32'(((m_cyc - 1) / int'(TB_HALF[m_id])) % 2));
                chk("play_done", 32'(done), 32'(m_cyc == PLAY_CYC));
                chk("play_busy", 32'(busy), 32'd1);
                chk("play_id",   32'(active_id), 32'(m_id));
                if (m_cyc == PLAY_CYC) begin
                    $display("[%0t] done id=%0d", $time, m_id);
                    dones++;
                    m_play = 1'b0; m_gap = 1'b1; m_gcyc = 0;
                end
            end else if (m_gap) begin
                m_gcyc++;
                chk("gap_busy", 32'(busy), 32'd1);
                chk("gap_snd",  32'(snd),  32'd0);
                chk("gap_done", 32'(done), 32'd0);
                chk("gap_id",   32'(active_id), 32'(m_id));
                if (m_gcyc == GAP_CYC) m_gap = 1'b0;
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_snd",  32'(snd),  32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_id",   32'(active_id), 32'(m_id));
            end
        end
    end

    // Wait until all expected grants have happened and the DUT has stayed idle
    // long enough that a leftover pending request would have been granted.
    task automatic wait_idle(input string nm);
        int streak;
        bit ok;
        streak = 0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge CLK); #1;
            if (busy === 1'b0 && q_exp.size() == 0 && !m_play && !m_gap) streak++;
            else streak = 0;
            if (streak >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_settle"}, 32'(ok), 32'd1);
        q_exp.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        d0 = dones;
        $display("[%0t] vector %s req0=%b req1=%b", $time, v.name, v.req0, v.req1);
        for (int i = 0; i < v.n_exp; i++) q_exp.push_back(v.exp_id[i]);
        @(posedge CLK); #1;
        req = v.req0;
        for (int i = 0; i < v.hold0; i++) begin
            @(posedge CLK); #1;
        end
        req = 4'b0000;
        if (v.d1 > 0) begin
            for (int i = v.hold0; i < v.d1; i++) begin
                @(posedge CLK); #1;
            end
            req = v.req1;
            @(posedge CLK); #1;
            req = 4'b0000;
        end
        wait_idle(v.name);
        chk({v.name, "_dones"}, 32'(dones - d0), 32'(PRE ? v.dones_pre : v.dones));
    endtask

    initial begin
        int d0;
        int cur;
        int pulses[3];

        //              name            req0  hold d1 req1   n  ids          dn pre
        vecs[0] = mk("single",       4'b0001, 1,  0, 4'b0000, 1, 0, 0, 0, 0, 1, 1);
        vecs[1] = mk("simul",        4'b1010, 1,  0, 4'b0000, 2, 3, 1, 0, 0, 2, 2);
        vecs[2] = mk("all4",         4'b1111, 1,  0, 4'b0000, 4, 3, 2, 1, 0, 4, 4);
        vecs[3] = mk("hold_regrant", 4'b0001, 2,  0, 4'b0000, 2, 0, 0, 0, 0, 2, 2);
        vecs[4] = mk("late_low",     4'b0100, 1,  3, 4'b0001, 2, 2, 0, 0, 0, 2, 2);
        vecs[5] = mk("preempt",      4'b0001, 1,  5, 4'b1000, 2, 0, 3, 0, 0, 2, 1);
        vecs[6] = mk("gap_req",      4'b1000, 1, 14, 4'b0010, 2, 3, 1, 0, 0, 2, 2);
        vecs[7] = mk("same_id",      4'b0100, 1,  4, 4'b0100, 2, 2, 2, 0, 0, 2, 2);

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_en = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Collapse: three req[0] pulses while id 2 plays give one id-0 tone.
        $display("[%0t] sequence collapse", $time);
        d0 = dones;
        q_exp.push_back(2);
        q_exp.push_back(0);
        pulses[0] = 2; pulses[1] = 5; pulses[2] = 9;
        @(posedge CLK); #1;
        req = 4'b0100;
        @(posedge CLK); #1;
        req = 4'b0000;
        cur = 1;
        for (int p = 0; p < 3; p++) begin
            while (cur < pulses[p]) begin
                @(posedge CLK); #1;
                cur++;
            end
            req = 4'b0001;
            @(posedge CLK); #1;
            cur++;
            req = 4'b0000;
        end
        wait_idle("collapse");
        chk("collapse_dones", 32'(dones - d0), 32'd2);

        // Reset mid-PLAY (cycle 6) with id 2 pending: tone aborted, nothing follows.
        $display("[%0t] sequence reset_mid_play", $time);
        d0 = dones;
        q_exp.push_back(3);
        @(posedge CLK); #1;
        req = 4'b1000;
        @(posedge CLK); #1;
        req = 4'b0100;
        @(posedge CLK); #1;
        req = 4'b0000;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
        end
        chk("reset_queue_empty", 32'(q_exp.size()), 32'd0);
        chk("reset_dones", 32'(dones - d0), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        wait_idle("reset_tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/tone_sched.md
TONE_SCHED -- requirements
Module: tone_sched

Interface
REQ-001 SHALL have parameter TICKS_PER_MS, default 25000, clock cycles per millisecond.
REQ-002 SHALL have parameter TONE_MS, default 300, tone duration in ms.
REQ-003 SHALL have parameter GAP_MS, default 50, silence between consecutive tones in ms.
REQ-004 SHALL have parameter HALF_P, 4x20-bit, default {28409,37879,47801,56818}, half-period in cycles per requester 3..0.
REQ-005 SHALL have ports: CLK in 1 system clock; RST in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: req in 4 tone request per requester, req[3] highest priority; snd out 1 speaker square wave.
REQ-007 SHALL have ports: busy out 1 state not IDLE; active_id out 2 requester being served; grant out 1 one-cycle pulse; done out 1 one-cycle pulse.

Function
REQ-008 SHALL keep a 4-bit pending register; each cycle pending <= pending | req, minus the bit cleared by a grant in that cycle.
REQ-009 SHALL implement the states IDLE, PLAY and GAP.
REQ-010 In IDLE, if (pending|req) is nonzero, SHALL on the next edge enter PLAY, load active_id with the highest set index, clear that pending bit, and assert grant for exactly that one cycle (1-cycle latency).
REQ-011 If the active requester's req is high in the grant cycle, its pending bit SHALL be set again.
REQ-012 In PLAY, snd SHALL start at 0 and toggle every HALF_P[active_id] cycles.
REQ-013 PLAY SHALL last exactly TONE_MS*TICKS_PER_MS cycles; on the last cycle done SHALL pulse, and the FSM SHALL move to GAP with snd forced to 0.
REQ-014 GAP SHALL last exactly GAP_MS*TICKS_PER_MS cycles, then return to IDLE; if GAP_MS=0, the FSM SHALL go directly from PLAY to IDLE.
REQ-015 Requests arriving during PLAY or GAP SHALL only set pending; none SHALL be lost, and repeats of the same id SHALL collapse into one.
REQ-016 Counters SHALL be sized with $clog2 of their maximum count, and SHALL never wrap within a state.
REQ-017 snd SHALL be 0 in IDLE and GAP; active_id SHALL hold its last value outside PLAY.

Reset
REQ-018 While RST is high on an edge: state=IDLE, pending=0, snd=0, busy=0, active_id=0, grant=0, done=0, all counters=0.
REQ-019 Reset asserted mid-PLAY SHALL abort the tone with no done pulse and discard all pending requests.

Configuration
REQ-020 Macro TONE_SCHED_PREEMPT_EN, when defined: in PLAY, a pending or req bit of higher index than active_id SHALL abort the current tone without a done pulse and without setting a pending bit for it; the new tone SHALL be granted on the next edge, with no GAP.
REQ-021 Without TONE_SCHED_PREEMPT_EN, a tone SHALL always play to completion, and higher-priority requests SHALL wait in pending.

Structure
REQ-022 Package tone_pkg SHALL hold the state enum (IDLE/PLAY/GAP), the requester ID constants (ID_LOSE=3, ID_LEVEL=2, ID_BTN_HI=1, ID_BTN_LO=0) and the ID width.
REQ-023 The square-wave divider SHALL be a sub-module tone_gen (inputs: enable, half-period; output: snd), restarted at every grant.

Verification (TICKS_PER_MS=4, TONE_MS=3, GAP_MS=1, HALF_P={2,3,4,5})
REQ-024 Single request: req=0001 for 1 cycle from IDLE -> grant next cycle, active_id=0, snd toggles every 5 cycles, done at cycle 12 of PLAY, busy drops 4 cycles later.
REQ-025 Simultaneous requests: req=1010 for 1 cycle -> id 3 played, then GAP, then id 1 granted with no further req; total 2 grants and 2 dones.
REQ-026 Collapse: req[0] pulsed 3 times during PLAY of id 2 -> exactly one later tone for id 0.
REQ-027 Preempt: id 0 playing, req[3] at PLAY cycle 5 -> with macro, grant id 3 next cycle and no done for id 0; without macro, id 0 completes, then GAP, then id 3.
REQ-028 Reset: RST high at PLAY cycle 6 with pending=0100 -> next cycle all outputs 0 and pending=0; nothing plays after RST drops.
